key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 2000000, the number of consecutive stable clocks needed to accept a new input level (20 ms at 100 MHz); legal range 2..2^24.
REQ-002 SHALL have port Clk  input  1  the single system clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port btn_raw  input  3  raw pushbuttons: bit0 confirm, bit1 lock, bit2 clear; each is asynchronous and active-high.
REQ-005 SHALL have port set_raw  input  1  raw password-set mode switch; asynchronous.
REQ-006 SHALL have port sw_raw  input  8  raw password switches; asynchronous.
REQ-007 SHALL have port confirm  output  1  one-cycle pulse when a debounced confirm press is accepted.
REQ-008 SHALL have port lock  output  1  one-cycle pulse when a debounced lock press is accepted.
REQ-009 SHALL have port reset  output  1  one-cycle pulse when a debounced clear press is accepted; this drives the downstream active-high clear.
REQ-010 SHALL have port pw_set  output  1  debounced level of set_raw.
REQ-011 SHALL have port pw_8  output  8  debounced switch bus.
REQ-012 SHALL have port sw_changed  output  1  one-cycle pulse in the cycle pw_8 takes a new value.

Function
REQ-013 SHALL pass each of btn_raw[2:0], set_raw and sw_raw[7:0] through a 2-flop synchronizer before any other logic.
REQ-014 SHALL give each button and set_raw its own debounce channel: stable register db, counter cnt of width clog2(DEB_CYCLES).
REQ-015 SHALL run each channel as follows: sync==db -> cnt<=0; sync!=db and cnt<DEB_CYCLES-1 -> cnt+1; sync!=db and cnt==DEB_CYCLES-1 -> db<=sync, cnt<=0.
REQ-016 SHALL restart the count whenever sync returns to db before acceptance, so a glitch shorter than DEB_CYCLES clocks is never accepted and cnt never wraps.
REQ-017 SHALL register the button pulse outputs as db & ~db_d; each pulse is exactly 1 cycle, and a held button produces no further pulses.
REQ-018 SHALL pulse nothing on release (db 1->0).
REQ-019 SHALL handle several button rises in the same cycle by priority reset > lock > confirm: only the highest is pulsed and the others are dropped, not deferred.
REQ-020 SHALL suppress confirm and lock pulses for 1 cycle after a reset pulse; a rise in that cycle is dropped.
REQ-021 SHALL debounce sw_raw as one 8-bit channel: candidate register cand, counter scnt.
REQ-022 SHALL handle the switch channel as follows: sync_bus!=cand -> cand<=sync_bus, scnt<=0; sync_bus==cand!=pw_8 -> scnt+1; when scnt==DEB_CYCLES-1 -> pw_8<=cand, sw_changed<=1 for 1 cycle, scnt<=0.
REQ-023 SHALL leave the switch channel idle when sync_bus==cand==pw_8: scnt<=0 and no pulse.
REQ-024 SHALL give a latency from a clean raw transition to its output change or pulse of exactly DEB_CYCLES+3 rising edges for buttons (2 sync + DEB_CYCLES + 1 pulse register), DEB_CYCLES+2 for pw_set, and DEB_CYCLES+3 for pw_8/sw_changed.
REQ-025 SHALL treat pw_set purely as a level; it has no pulse and does not take part in button priority.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously clear all synchronizers, db, db_d, cand, cnt, scnt, pw_8 and pw_set, and drive confirm=lock=reset=sw_changed=0.
REQ-027 SHALL abandon any debounce in progress when reset is asserted mid-count; no pulse is emitted for it after release.
REQ-028 SHALL release reset synchronously, using an internal 2-flop reset synchronizer (async assert, sync deassert).
REQ-029 SHALL treat a button held through reset release as a new press: it produces one pulse DEB_CYCLES+3 edges after release.

Verification (DEB_CYCLES=4)
REQ-030 SHALL be tested with a clean confirm press held 20 cycles -> confirm=1 for exactly 1 cycle, 7 edges after the raw rise; no pulse on release.
REQ-031 SHALL be tested with a lock bounce of 3-cycle high, 1-cycle low, then held high -> exactly one lock pulse, 7 edges after the final rise.
REQ-032 SHALL be tested with confirm and clear rising in the same cycle -> reset pulse only; confirm stays 0 throughout.
REQ-033 SHALL be tested with sw_raw 0x00->0xA5, then 0x5A two cycles later, then held -> pw_8 never shows 0xA5; pw_8=0x5A with one sw_changed pulse, 7 edges after the 0x5A change.
REQ-034 SHALL be tested with reset_n pulled low at count 3 of a confirm press, then released -> no pulse from the aborted press; with the button still held, one pulse 7 edges after release.
REQ-035 SHALL be tested with set_raw high for 3 cycles, then high for 10 cycles -> pw_set stays 0 for the first window and goes 1 exactly 6 edges after the second rise.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner
//   Synchronizes and debounces the keypad front panel of the lock.
//   Buttons become single-cycle pulses, the set switch becomes a clean
//   level, and the 8-bit password switch bus is debounced as one word.
//
// Ports
//   Clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   btn_raw    in   [0] confirm, [1] lock, [2] clear (async, active-high)
//   set_raw    in   password-set mode switch (async)
//   sw_raw     in   [7:0] password switches (async)
//   confirm    out  one-cycle pulse per accepted confirm press
//   lock       out  one-cycle pulse per accepted lock press
//   reset      out  one-cycle pulse per accepted clear press
//   pw_set     out  debounced set_raw level
//   pw_8       out  [7:0] debounced switch word
//   sw_changed out  one-cycle pulse when pw_8 takes a new value
module key_conditioner #(
    parameter int unsigned DEB_CYCLES = 2000000
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [2:0] btn_raw,
    input  logic       set_raw,
    input  logic [7:0] sw_raw,
    output logic       confirm,
    output logic       lock,
    output logic       reset,
    output logic       pw_set,
    output logic [7:0] pw_8,
    output logic       sw_changed
);

    localparam int unsigned    CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

    // Reset synchronizer: asserts immediately, releases two edges later.
    logic [1:0] rst_pipe;
    logic       rst_int_n;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    // Input synchronizers. They are cleared by the raw reset so they refill
    // while the internal reset is still releasing; a button held through
    // reset release is therefore seen by the debouncers on their first
    // active edge.
    logic [3:0] ch_meta, ch_sync;   // {set, clear, lock, confirm}
    logic [7:0] sw_meta, sw_sync;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_meta <= '0;
            ch_sync <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            ch_meta <= {set_raw, btn_raw};
            ch_sync <= ch_meta;
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
        end
    end

    // Per-bit debounce channels for the three buttons and the set switch.
    logic [3:0]    db;
    logic [CW-1:0] cnt [4];

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            db <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (ch_sync[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= ch_sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign pw_set = db[3];

    // Button pulses: rising edge of the debounced level, resolved by
    // priority clear > lock > confirm. Losing rises are consumed by db_d
    // and never re-issued; the cycle after a clear pulse masks the others.
    logic [2:0] db_d;
    logic [2:0] rise;

    assign rise = db[2:0] & ~db_d;

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            db_d    <= '0;
            reset   <= 1'b0;
            lock    <= 1'b0;
            confirm <= 1'b0;
        end else begin
            db_d    <= db[2:0];
            reset   <= rise[2];
            lock    <= rise[1] & ~rise[2] & ~reset;
            confirm <= rise[0] & ~rise[1] & ~rise[2] & ~reset;
        end
    end

    // Switch word channel: any change of the synchronized bus restarts the
    // candidate; a candidate that differs from pw_8 and holds long enough
    // is committed.
    logic [7:0]    cand;
    logic [CW-1:0] scnt;

    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cand       <= '0;
            scnt       <= '0;
            pw_8       <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= 1'b0;
            if (sw_sync != cand) begin
                cand <= sw_sync;
                scnt <= '0;
            end else if (cand != pw_8) begin
                if (scnt == CNT_MAX) begin
                    pw_8       <= cand;
                    sw_changed <= 1'b1;
                    scnt       <= '0;
                end else begin
                    scnt <= scnt + CW'(1);
                end
            end else begin
                scnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int unsigned DEB = 4;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic [2:0] btn_raw;
    logic       set_raw;
    logic [7:0] sw_raw;
    logic       confirm;
    logic       lock;
    logic       reset;
    logic       pw_set;
    logic [7:0] pw_8;
    logic       sw_changed;

    int n_cmp = 0;
    int n_err = 0;

    key_conditioner #(.DEB_CYCLES(DEB)) dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .set_raw    (set_raw),
        .sw_raw     (sw_raw),
        .confirm    (confirm),
        .lock       (lock),
        .reset      (reset),
        .pw_set     (pw_set),
        .pw_8       (pw_8),
        .sw_changed (sw_changed)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_and_idle();
        reset_n = 1'b0;
        btn_raw = '0;
        set_raw = 1'b0;
        sw_raw  = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [12:0] got;
        reset_n = 1'b1;
        btn_raw = '0;
        set_raw = 1'b0;
        sw_raw  = '0;
        #2;
        reset_n = 1'b0;
        #1;
        got = {confirm, lock, reset, pw_set, sw_changed, pw_8};
        n_cmp++;
        if (got !== 13'h0) begin
            n_err++;
            $display("FAIL reset_async: outputs=%h expected 0", got);
        end
        btn_raw = 3'b111;
        set_raw = 1'b1;
        sw_raw  = 8'hFF;
        for (int k = 1; k <= 10; k++) begin
            tick();
            got = {confirm, lock, reset, pw_set, sw_changed, pw_8};
            n_cmp++;
            if (got !== 13'h0) begin
                n_err++;
                $display("FAIL reset_held edge %0d: outputs=%h expected 0", k, got);
            end
        end
        btn_raw = '0;
        set_raw = 1'b0;
        sw_raw  = '0;
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            got = {confirm, lock, reset, pw_set, sw_changed, pw_8};
            n_cmp++;
            if (got !== 13'h0) begin
                n_err++;
                $display("FAIL reset_quiet edge %0d: outputs=%h expected 0", k, got);
            end
        end
    endtask

    task automatic test_confirm();
        logic exp;
        reset_and_idle();
        btn_raw = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k == 7);
            n_cmp++;
            if (confirm !== exp) begin
                n_err++;
                $display("FAIL confirm_press edge %0d: confirm=%b expected %b", k, confirm, exp);
            end
            n_cmp++;
            if ({lock, reset} !== 2'b00) begin
                n_err++;
                $display("FAIL confirm_others edge %0d: lock,reset=%b expected 00", k, {lock, reset});
            end
        end
        btn_raw = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_cmp++;
            if (confirm !== 1'b0) begin
                n_err++;
                $display("FAIL confirm_release edge %0d: confirm=%b expected 0", k, confirm);
            end
        end
    endtask

    task automatic test_lock_bounce();
        logic exp;
        reset_and_idle();
        for (int k = 1; k <= 25; k++) begin
            btn_raw = {1'b0, (k <= 3 || k >= 5), 1'b0};
            tick();
            exp = (k == 11);
            n_cmp++;
            if (lock !== exp) begin
                n_err++;
                $display("FAIL lock_bounce edge %0d: lock=%b expected %b", k, lock, exp);
            end
            n_cmp++;
            if ({confirm, reset} !== 2'b00) begin
                n_err++;
                $display("FAIL lock_bounce_others edge %0d: confirm,reset=%b expected 00", k, {confirm, reset});
            end
        end
    endtask

    task automatic test_priority();
        logic exp;
        reset_and_idle();
        btn_raw = 3'b101;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k == 7);
            n_cmp++;
            if (reset !== exp) begin
                n_err++;
                $display("FAIL priority_reset edge %0d: reset=%b expected %b", k, reset, exp);
            end
            n_cmp++;
            if ({confirm, lock} !== 2'b00) begin
                n_err++;
                $display("FAIL priority_drop edge %0d: confirm,lock=%b expected 00", k, {confirm, lock});
            end
        end
        btn_raw = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_cmp++;
            if ({confirm, reset} !== 2'b00) begin
                n_err++;
                $display("FAIL priority_release edge %0d: confirm,reset=%b expected 00", k, {confirm, reset});
            end
        end
    endtask

    task automatic test_suppress();
        logic exp_r;
        logic exp_l;
        for (int off = 1; off <= 2; off++) begin
            reset_and_idle();
            for (int k = 1; k <= 20; k++) begin
                btn_raw = {1'b1, (k >= off + 1), 1'b0};
                tick();
                exp_r = (k == 7);
                exp_l = (off == 2) && (k == 9);
                n_cmp++;
                if (reset !== exp_r) begin
                    n_err++;
                    $display("FAIL suppress_reset off %0d edge %0d: reset=%b expected %b", off, k, reset, exp_r);
                end
                n_cmp++;
                if (lock !== exp_l) begin
                    n_err++;
                    $display("FAIL suppress_lock off %0d edge %0d: lock=%b expected %b", off, k, lock, exp_l);
                end
            end
        end
    endtask

    task automatic test_switch();
        logic [7:0] exp_pw;
        logic       exp_chg;
        reset_and_idle();
        for (int k = 1; k <= 20; k++) begin
            sw_raw = (k >= 3) ? 8'h5A : 8'hA5;
            tick();
            exp_pw  = (k >= 9) ? 8'h5A : 8'h00;
            exp_chg = (k == 9);
            n_cmp++;
            if (pw_8 !== exp_pw) begin
                n_err++;
                $display("FAIL switch_word edge %0d: pw_8=%h expected %h", k, pw_8, exp_pw);
            end
            n_cmp++;
            if (sw_changed !== exp_chg) begin
                n_err++;
                $display("FAIL switch_pulse edge %0d: sw_changed=%b expected %b", k, sw_changed, exp_chg);
            end
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({pw_8, sw_changed} !== 9'h0) begin
            n_err++;
            $display("FAIL switch_async_clear: pw_8,sw_changed=%h expected 0", {pw_8, sw_changed});
        end
    endtask

    task automatic test_reset_abort();
        logic exp;
        reset_and_idle();
        btn_raw = 3'b001;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if (confirm !== 1'b0) begin
                n_err++;
                $display("FAIL abort_pre edge %0d: confirm=%b expected 0", k, confirm);
            end
        end
        reset_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if ({confirm, lock, reset} !== 3'b000) begin
                n_err++;
                $display("FAIL abort_held edge %0d: pulses=%b expected 000", k, {confirm, lock, reset});
            end
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (k == 7);
            n_cmp++;
            if (confirm !== exp) begin
                n_err++;
                $display("FAIL abort_repress edge %0d: confirm=%b expected %b", k, confirm, exp);
            end
        end
        btn_raw = 3'b000;
    endtask

    task automatic test_set_level();
        logic exp;
        reset_and_idle();
        for (int k = 1; k <= 26; k++) begin
            set_raw = (k <= 3) || (k >= 7 && k <= 16);
            tick();
            exp = (k >= 12 && k <= 21);
            n_cmp++;
            if (pw_set !== exp) begin
                n_err++;
                $display("FAIL set_level edge %0d: pw_set=%b expected %b", k, pw_set, exp);
            end
            n_cmp++;
            if ({confirm, lock, reset} !== 3'b000) begin
                n_err++;
                $display("FAIL set_no_pulse edge %0d: pulses=%b expected 000", k, {confirm, lock, reset});
            end
        end
    endtask

    // Reference: a level is accepted once the synchronized input (raw
    // delayed two edges) has differed from the stable value for DEB
    // consecutive samples; the word is accepted once DEB+1 consecutive
    // samples agree on a value other than pw_8. Pulses follow acceptance
    // by one edge, with clear > lock > confirm and one masked cycle after
    // a clear pulse.
    task automatic test_random();
        logic [11:0] hist[$];
        logic [11:0] h;
        logic [3:0]  stable;
        logic [7:0]  pw;
        logic [7:0]  v;
        logic [2:0]  pend;
        logic        e_conf, e_lock, e_rst, e_chg;
        logic        n_conf, n_lock, n_rst;
        logic        all_diff, same;
        logic [12:0] exp_v, got_v;
        int unsigned hold[5];
        int          n;
        int unsigned hh;

        reset_n = 1'b0;
        btn_raw = '0;
        set_raw = 1'b0;
        sw_raw  = '0;
        repeat (2) tick();
        stable = '0;
        pw     = '0;
        pend   = '0;
        e_conf = 1'b0;
        e_lock = 1'b0;
        e_rst  = 1'b0;
        e_chg  = 1'b0;
        for (int c = 0; c < 5; c++) hold[c] = 0;
        reset_n = 1'b1;

        for (int k = 1; k <= 1500; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                btn_raw = 3'($urandom_range(0, 7));
                hh = $urandom_range(1, 9);
                for (int c = 0; c < 3; c++) hold[c] = hh;
            end
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    if (c < 3) btn_raw[c] = ~btn_raw[c];
                    else       set_raw    = ~set_raw;
                    hold[c] = $urandom_range(1, 9);
                end else begin
                    hold[c] = hold[c] - 1;
                end
            end
            if (hold[4] == 0) begin
                case ($urandom_range(0, 3))
                    0:       sw_raw = 8'h00;
                    1:       sw_raw = 8'hA5;
                    2:       sw_raw = 8'h5A;
                    default: sw_raw = 8'($urandom);
                endcase
                hold[4] = $urandom_range(1, 9);
            end else begin
                hold[4] = hold[4] - 1;
            end
            hist.push_back({sw_raw, set_raw, btn_raw});

            tick();

            n_rst  = pend[2];
            n_lock = pend[1] & ~pend[2] & ~e_rst;
            n_conf = pend[0] & ~pend[1] & ~pend[2] & ~e_rst;
            pend   = '0;
            e_chg  = 1'b0;
            if (k >= 3) begin
                n = k - 2;
                for (int c = 0; c < 4; c++) begin
                    if (n >= int'(DEB)) begin
                        all_diff = 1'b1;
                        for (int j = n - int'(DEB); j < n; j++) begin
                            h = hist[j];
                            if (h[c] == stable[c]) all_diff = 1'b0;
                        end
                        if (all_diff) begin
                            if (c < 3 && !stable[c]) pend[c] = 1'b1;
                            stable[c] = ~stable[c];
                        end
                    end
                end
                if (n >= int'(DEB) + 1) begin
                    h    = hist[n - 1];
                    v    = h[11:4];
                    same = 1'b1;
                    for (int j = n - int'(DEB) - 1; j < n; j++) begin
                        h = hist[j];
                        if (h[11:4] != v) same = 1'b0;
                    end
                    if (same && v != pw) begin
                        pw    = v;
                        e_chg = 1'b1;
                    end
                end
            end
            e_rst  = n_rst;
            e_lock = n_lock;
            e_conf = n_conf;

            exp_v = {e_conf, e_lock, e_rst, stable[3], e_chg, pw};
            got_v = {confirm, lock, reset, pw_set, sw_changed, pw_8};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL random edge %0d: {confirm,lock,reset,pw_set,sw_changed,pw_8}=%h expected %h",
                         k, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_confirm();
        test_lock_bounce();
        test_priority();
        test_suppress();
        test_switch();
        test_reset_abort();
        test_set_level();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
